// File: rtl/wb_checker_if.sv
// Writeback-checker bus: expected-entry push channel, pipeline writeback
// port and the scoreboard status outputs, with master (bench/pipeline) and slave (checker) views.
interface wb_checker_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic              exp_valid;
    logic              exp_ready;
    logic [4:0]        exp_addr;
    logic [XLEN-1:0]   exp_data;
    logic              wb_e;
    logic [4:0]        wb_a;
    logic [XLEN-1:0]   wb_d;
    logic [PW-1:0]     pending;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic              err;
    logic [1:0]        err_code;
    logic [4:0]        err_addr;
    logic [XLEN-1:0]   err_data;

    modport master (
        output exp_valid, exp_addr, exp_data, wb_e, wb_a, wb_d,
        input  exp_ready, pending, pass_cnt, fail_cnt, err, err_code, err_addr, err_data
    );

    modport slave (
        input  exp_valid, exp_addr, exp_data, wb_e, wb_a, wb_d,
        output exp_ready, pending, pass_cnt, fail_cnt, err, err_code, err_addr, err_data
    );
endinterface

// File: rtl/wb_checker.sv
// In-order writeback scoreboard: FIFO of expected register writes compared against
// retired writebacks. Define WB_CHECK_TIMEOUT_EN to build the head-entry watchdog.
module wb_checker #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    wb_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [4:0]       mem_addr_q [DEPTH];
    logic [XLEN-1:0]  mem_data_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [PW-1:0]    pending_q;
    logic [PW-1:0]    pending_d;
    logic             exp_ready_q;
    logic             exp_ready_d;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] pass_cnt_q;
    logic [CNT_W-1:0] fail_cnt_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic [4:0]       err_addr_q;
    logic [XLEN-1:0]  err_data_q;

    logic             push_s;
    logic             obs_s;
    logic             empty_s;
    logic             timeout_s;
    logic             pop_s;
    logic [4:0]       head_addr_s;
    logic [XLEN-1:0]  head_data_s;
    logic             pass_hit_s;
    logic             err_hit_s;
    logic [1:0]       err_code_s;
    logic [4:0]       err_addr_s;
    logic [XLEN-1:0]  err_data_s;

`ifdef WB_CHECK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT);
    logic [WD_W-1:0]  wd_q;
    logic [WD_W-1:0]  wd_d;
`else
    logic             unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT >= 2);
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Handshake decode, head lookup and watchdog expiry.
    always_comb begin
        push_s      = bus.exp_valid && exp_ready_q;
        obs_s       = bus.wb_e && (bus.wb_a != 5'd0);
        empty_s     = (pending_q == PW'(0));
        head_addr_s = mem_addr_q[rd_ptr_q];
        head_data_s = mem_data_q[rd_ptr_q];
`ifdef WB_CHECK_TIMEOUT_EN
        // An observed event in the expiry cycle takes precedence over the timeout.
        timeout_s   = (state_q == ST_WAIT) && !obs_s && (wd_q == WD_W'(TIMEOUT - 1));
`else
        timeout_s   = 1'b0;
`endif
        pop_s       = (obs_s && !empty_s) || timeout_s;
    end

    // Classify this cycle's outcome and compute the next occupancy and state.
    always_comb begin
        pass_hit_s = 1'b0;
        err_hit_s  = 1'b0;
        err_code_s = 2'b00;
        err_addr_s = 5'd0;
        err_data_s = {XLEN{1'b0}};
        if (obs_s) begin
            if (empty_s) begin
                err_hit_s  = 1'b1;
                err_code_s = 2'b10;
                err_addr_s = bus.wb_a;
                err_data_s = bus.wb_d;
            end else if ((head_addr_s != bus.wb_a) || (head_data_s != bus.wb_d)) begin
                err_hit_s  = 1'b1;
                err_code_s = 2'b01;
                err_addr_s = bus.wb_a;
                err_data_s = bus.wb_d;
            end else begin
                pass_hit_s = 1'b1;
            end
        end else if (timeout_s) begin
            err_hit_s  = 1'b1;
            err_code_s = 2'b11;
            err_addr_s = head_addr_s;
            err_data_s = head_data_s;
        end else begin
            pass_hit_s = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
        exp_ready_d = (pending_d < PW'(DEPTH));

        case (state_q)
            ST_IDLE: begin
                if (push_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (pop_s && !push_s && (pending_q == PW'(1))) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef WB_CHECK_TIMEOUT_EN
    // Watchdog: restarts on any pop or observed event, counts only while waiting.
    always_comb begin
        if (pop_s || obs_s) begin
            wd_d = {WD_W{1'b0}};
        end else if (state_q == ST_WAIT) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = {WD_W{1'b0}};
        end
    end
`endif

    // Entry storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_addr_q[wr_ptr_q] <= bus.exp_addr;
            mem_data_q[wr_ptr_q] <= bus.exp_data;
        end
    end

    // Control state, counters and first-error capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= {AW{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            pending_q   <= {PW{1'b0}};
            exp_ready_q <= 1'b1;
            pass_cnt_q  <= {CNT_W{1'b0}};
            fail_cnt_q  <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            err_addr_q  <= 5'd0;
            err_data_q  <= {XLEN{1'b0}};
`ifdef WB_CHECK_TIMEOUT_EN
            wd_q        <= {WD_W{1'b0}};
`endif
        end else if (clear) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= {AW{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            pending_q   <= {PW{1'b0}};
            exp_ready_q <= 1'b1;
            pass_cnt_q  <= {CNT_W{1'b0}};
            fail_cnt_q  <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            err_addr_q  <= 5'd0;
            err_data_q  <= {XLEN{1'b0}};
`ifdef WB_CHECK_TIMEOUT_EN
            wd_q        <= {WD_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            exp_ready_q <= exp_ready_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (pass_hit_s) begin
                pass_cnt_q <= sat_inc(pass_cnt_q);
            end
            if (err_hit_s) begin
                fail_cnt_q <= sat_inc(fail_cnt_q);
                if (!err_q) begin
                    err_q      <= 1'b1;
                    err_code_q <= err_code_s;
                    err_addr_q <= err_addr_s;
                    err_data_q <= err_data_s;
                end
            end
`ifdef WB_CHECK_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign bus.exp_ready = exp_ready_q;
    assign bus.pending   = pending_q;
    assign bus.pass_cnt  = pass_cnt_q;
    assign bus.fail_cnt  = fail_cnt_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.err_data  = err_data_q;
endmodule

// File: tb/tb_wb_checker.sv
// Self-checking bench for wb_checker: a queue mirrors the expected-entry FIFO and is
// popped as writebacks are driven; each scenario task compares DUT outputs inline.
module tb_wb_checker;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk;
    logic reset_n;
    logic clear;

    wb_checker_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    wb_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus)
    );

    ent_t        m_q[$];
    int          m_pass;
    int          m_fail;
    logic        m_err;
    logic [1:0]  m_code;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_wd;
    int          errors;
    int          checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

    task automatic model_reset();
        m_q.delete();
        m_pass = 0;
        m_fail = 0;
        m_err  = 1'b0;
        m_code = 2'b00;
        m_addr = 5'd0;
        m_data = 32'd0;
        m_wd   = 0;
    endtask

    task automatic model_error(input logic [1:0] c, input logic [4:0] a, input logic [31:0] d);
        m_fail++;
        if (!m_err) begin
            m_err  = 1'b1;
            m_code = c;
            m_addr = a;
            m_data = d;
        end
    endtask

    function automatic logic [76:0] dut_vec();
        return {bus.pending, bus.exp_ready, bus.pass_cnt, bus.fail_cnt,
                bus.err, bus.err_code, bus.err_addr, bus.err_data};
    endfunction

    function automatic logic [76:0] model_vec();
        logic [3:0] p;
        logic       rdy;
        p   = 4'(m_q.size());
        rdy = (m_q.size() < DEPTH);
        return {p, rdy, 16'(m_pass), 16'(m_fail), m_err, m_code, m_addr, m_data};
    endfunction

    // One clock of stimulus; the scoreboard queue is updated as the stimulus is applied.
    task automatic cycle(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic clr);
        bit   acc;
        bit   obs;
        bit   emp;
        ent_t h;
        bus.exp_valid = pv;
        bus.exp_addr  = pa;
        bus.exp_data  = pd;
        bus.wb_e      = we;
        bus.wb_a      = wa;
        bus.wb_d      = wd;
        clear         = clr;
        if (clr) begin
            model_reset();
        end else begin
            emp = (m_q.size() == 0);
            acc = pv && (m_q.size() < DEPTH);
            obs = we && (wa != 5'd0);
            if (obs) begin
                if (emp) begin
                    model_error(2'b10, wa, wd);
                end else begin
                    h = m_q.pop_front();
                    if (h.a == wa && h.d == wd) m_pass++;
                    else model_error(2'b01, wa, wd);
                end
                m_wd = 0;
            end
`ifdef WB_CHECK_TIMEOUT_EN
            else if (!emp && m_wd == TIMEOUT - 1) begin
                h = m_q.pop_front();
                model_error(2'b11, h.a, h.d);
                m_wd = 0;
            end else if (!emp) begin
                m_wd++;
            end
`endif
            if (acc) m_q.push_back('{a: pa, d: pd});
        end
        @(posedge clk);
        #1;
        bus.exp_valid = 1'b0;
        bus.wb_e      = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        cycle(1'b1, a, d, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, a, d, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic do_clear();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== {4'd0, 1'b1, 16'd0, 16'd0, 1'b0, 2'b00, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(),
                     {4'd0, 1'b1, 16'd0, 16'd0, 1'b0, 2'b00, 5'd0, 32'd0});
        end
        reset_n = 1'b1;
        idle();
    endtask

    task automatic test_match();
        push(5'd1, 32'hDEADBEEF);
        push(5'd2, 32'h12345678);
        checks++;
        if (bus.pending !== 4'd2) begin
            errors++;
            $display("FAIL match_pending2: got %0d expected 2", bus.pending);
        end
        wb(5'd1, 32'hDEADBEEF);
        idle();
        idle();
        wb(5'd2, 32'h12345678);
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt, bus.err, bus.pending} !== {16'd2, 16'd0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL match_result: got pass=%0d fail=%0d err=%b pending=%0d expected 2 0 0 0",
                     bus.pass_cnt, bus.fail_cnt, bus.err, bus.pending);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL match_state: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_mismatch();
        push(5'd3, 32'hFEDCBA98);
        wb(5'd3, 32'hFEDCBA99);
        checks++;
        if ({bus.fail_cnt, bus.err_code, bus.err_addr, bus.err_data} !==
            {16'd1, 2'b01, 5'd3, 32'hFEDCBA99}) begin
            errors++;
            $display("FAIL mismatch_first: got fail=%0d code=%b addr=%0d data=%h expected 1 01 3 fedcba99",
                     bus.fail_cnt, bus.err_code, bus.err_addr, bus.err_data);
        end
        push(5'd6, 32'h00000011);
        wb(5'd6, 32'h00000022);
        checks++;
        if ({bus.fail_cnt, bus.err, bus.err_code, bus.err_addr, bus.err_data} !==
            {16'd2, 1'b1, 2'b01, 5'd3, 32'hFEDCBA99}) begin
            errors++;
            $display("FAIL mismatch_sticky: got fail=%0d code=%b addr=%0d data=%h expected 2 01 3 fedcba99",
                     bus.fail_cnt, bus.err_code, bus.err_addr, bus.err_data);
        end
    endtask

    task automatic test_unexpected();
        do_clear();
        wb(5'd5, 32'h00000001);
        checks++;
        if ({bus.fail_cnt, bus.err_code, bus.err_addr, bus.err_data, bus.pending} !==
            {16'd1, 2'b10, 5'd5, 32'h1, 4'd0}) begin
            errors++;
            $display("FAIL unexpected_empty: got fail=%0d code=%b addr=%0d data=%h pending=%0d expected 1 10 5 1 0",
                     bus.fail_cnt, bus.err_code, bus.err_addr, bus.err_data, bus.pending);
        end
        wb(5'd0, 32'h00001234);
        checks++;
        if ({bus.pass_cnt, bus.fail_cnt} !== {16'd0, 16'd1}) begin
            errors++;
            $display("FAIL x0_ignored: got pass=%0d fail=%0d expected 0 1", bus.pass_cnt, bus.fail_cnt);
        end
        // Push and writeback together on an empty FIFO: unexpected, entry still stored.
        cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h9, 1'b0);
        checks++;
        if ({bus.fail_cnt, bus.pending} !== {16'd2, 4'd1}) begin
            errors++;
            $display("FAIL push_and_unexpected: got fail=%0d pending=%0d expected 2 1",
                     bus.fail_cnt, bus.pending);
        end
        wb(5'd7, 32'h77);
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL unexpected_state: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < DEPTH; i++) push(5'(i + 1), $urandom());
        checks++;
        if ({bus.pending, bus.exp_ready} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL full_flag: got pending=%0d ready=%b expected 8 0", bus.pending, bus.exp_ready);
        end
        push(5'd9, 32'h99999999);
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL full_drop: got %h expected %h", dut_vec(), model_vec());
        end
        wb(m_q[0].a, m_q[0].d);
        cycle(1'b1, 5'd10, 32'hA0A0A0A0, 1'b1, m_q[0].a, m_q[0].d, 1'b0);
        checks++;
        if ({bus.pending, bus.pass_cnt} !== {4'd7, 16'd2}) begin
            errors++;
            $display("FAIL push_pop_same: got pending=%0d pass=%0d expected 7 2", bus.pending, bus.pass_cnt);
        end
    endtask

    task automatic test_back_to_back();
        while (m_q.size() != 0) wb(m_q[0].a, m_q[0].d);
        checks++;
        if ({bus.pending, bus.pass_cnt, bus.fail_cnt, bus.err} !== {4'd0, 16'd9, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL back_to_back: got pending=%0d pass=%0d fail=%0d err=%b expected 0 9 0 0",
                     bus.pending, bus.pass_cnt, bus.fail_cnt, bus.err);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL back_to_back_state: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_timeout();
        do_clear();
        push(5'd4, 32'hA5A5A5A5);
`ifdef WB_CHECK_TIMEOUT_EN
        repeat (TIMEOUT - 1) idle();
        checks++;
        if ({bus.err, bus.pending} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL timeout_early: got err=%b pending=%0d expected 0 1", bus.err, bus.pending);
        end
        idle();
        checks++;
        if ({bus.err_code, bus.err_addr, bus.err_data, bus.pending, bus.fail_cnt} !==
            {2'b11, 5'd4, 32'hA5A5A5A5, 4'd0, 16'd1}) begin
            errors++;
            $display("FAIL timeout_fire: got code=%b addr=%0d data=%h pending=%0d fail=%0d expected 11 4 a5a5a5a5 0 1",
                     bus.err_code, bus.err_addr, bus.err_data, bus.pending, bus.fail_cnt);
        end
`else
        repeat (100) idle();
        checks++;
        if ({bus.err, bus.pending, bus.fail_cnt} !== {1'b0, 4'd1, 16'd0}) begin
            errors++;
            $display("FAIL no_timeout: got err=%b pending=%0d fail=%0d expected 0 1 0",
                     bus.err, bus.pending, bus.fail_cnt);
        end
`endif
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL timeout_state: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_midop();
        do_clear();
        for (int i = 0; i < 4; i++) push(5'(i + 11), 32'h5000_0000 + 32'(i));
        wb(5'd11, 32'h0BAD0BAD);
        checks++;
        if ({bus.pending, bus.err} !== {4'd3, 1'b1}) begin
            errors++;
            $display("FAIL midop_setup: got pending=%0d err=%b expected 3 1", bus.pending, bus.err);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== {4'd0, 1'b1, 16'd0, 16'd0, 1'b0, 2'b00, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(),
                     {4'd0, 1'b1, 16'd0, 16'd0, 1'b0, 2'b00, 5'd0, 32'd0});
        end
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push(5'(i + 11), 32'h6000_0000 + 32'(i));
        wb(5'd11, 32'h0BAD0BAD);
        // Clear wins over a push offered in the same cycle.
        cycle(1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 32'd0, 1'b1);
        checks++;
        if (dut_vec() !== {4'd0, 1'b1, 16'd0, 16'd0, 1'b0, 2'b00, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL sync_clear: got %h expected %h", dut_vec(),
                     {4'd0, 1'b1, 16'd0, 16'd0, 1'b0, 2'b00, 5'd0, 32'd0});
        end
        push(5'd12, 32'h12);
        wb(5'd12, 32'h12);
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL after_clear: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        clear         = 1'b0;
        reset_n       = 1'b0;
        bus.exp_valid = 1'b0;
        bus.exp_addr  = 5'd0;
        bus.exp_data  = 32'd0;
        bus.wb_e      = 1'b0;
        bus.wb_a      = 5'd0;
        bus.wb_d      = 32'd0;
        test_reset();
        test_match();
        test_mismatch();
        test_unexpected();
        test_full();
        test_back_to_back();
        test_timeout();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
